enqueue_agent_mc: RTL
=====================

Name: enqueue_agent_mc

Overview:
Parametrised successor of the single-mode enqueue agent: classifies each incoming packet on its first beat, then either enqueues it (packet/meta buffer writes plus PIFO enqueue) or drops the whole packet.
- Generalised in output-port count, PIFO block count and destination-field position.
- Adds a registered output stage, input backpressure, and a saturating drop counter.
- Sits between the P4 pipeline output and the packet buffer / PIFO scheduler.

Parameters:
DATA_WIDTH, 256, packet data bus width
KEEP_WIDTH, 32, byte-keep width (DATA_WIDTH/8)
SUME_WIDTH, 128, SUME metadata width
PIFO_INFO_WIDTH, 37, per-block pifo_info width; valid bit is its MSB
PIFO_BLOCK_COUNT, 5, PIFO blocks; localparam PIFO_WIDTH = PIFO_INFO_WIDTH*PIFO_BLOCK_COUNT
OUTPUT_PORT_COUNT, 5, output ports, >=2
DST_POS, 24, LSB of the 8-bit dst_port field in SUME meta
DROP_CNT_WIDTH, 32, drop counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axis_pkt_data  in  DATA_WIDTH  beat data
s_axis_pkt_keep  in  KEEP_WIDTH  beat keep
s_axis_pkt_last  in  1  last beat of packet
s_axis_sume_meta  in  SUME_WIDTH+PIFO_WIDTH  {pifo_info, sume_meta}; sampled on first beat only
s_axis_valid  in  1  beat valid
s_axis_ready  out  1  beat accepted when valid&ready
s_axis_wr_ready  in  1  buffer can take a write next cycle
s_axis_buffer_almost_full_bit_array  in  OUTPUT_PORT_COUNT  per-port buffer almost full
s_axis_pifo_almost_full_bit_array  in  PIFO_BLOCK_COUNT  per-block PIFO almost full
m_axis_pkt_info  out  DATA_WIDTH+KEEP_WIDTH+1  {data, keep, last}
m_axis_sume_meta  out  SUME_WIDTH  sume meta of current packet
m_axis_pifo_info  out  PIFO_WIDTH  pifo info of current packet
m_axis_output_port_bit_array  out  OUTPUT_PORT_COUNT  destination port map
m_axis_ctl_pkt_wr_en  out  1  write packet beat
m_axis_ctl_meta_wr_en  out  1  write metadata
m_axis_ctl_pifo_enq  out  1  enqueue PIFO info
m_axis_ctl_pkt_addr_update  out  1  advance packet address
m_axis_ctl_meta_addr_update  out  1  advance meta address
drop_cnt  out  DROP_CNT_WIDTH  dropped packets, saturating

Behaviour:
- s_axis_ready = s_axis_wr_ready & ~rst (combinational). A beat is "accepted" = valid & ready.
- Port map (combinational from the first beat):
  - bit i, for i < OUTPUT_PORT_COUNT-1: meta[DST_POS+2i].
  - Top bit: OR of the odd bits meta[DST_POS+1], +3, +5, +7 (CPU port).
- Full checks:
  - buf_full = |(buffer_almost_full & port_map).
  - pifo_full = OR over k of (pifo_almost_full[k] & pifo_info[k*PIFO_INFO_WIDTH+PIFO_INFO_WIDTH-1]).
- FSM states IDLE/ENQUEUE/DROP, one always_ff; reset state IDLE.
  - IDLE, accepted beat, ~buf_full & ~pifo_full: all five ctl strobes pulse; latch meta/pifo/port map. Next state is ENQUEUE if ~last, else IDLE.
  - IDLE, accepted beat, either full: no strobes; drop_cnt+1. Next state is DROP if ~last, else IDLE.
  - ENQUEUE, accepted beat: pkt_wr_en and pkt_addr_update pulse; on last, go to IDLE.
  - DROP, accepted beat: no strobes; on last, go to IDLE.
  - No accepted beat: hold state, no strobes.
- Latency: every output is registered, one cycle after acceptance. pkt_info, strobes and port map for beat n appear together at cycle n+1.
- m_axis_sume_meta, m_axis_pifo_info and m_axis_output_port_bit_array hold the first-beat values for the whole packet.
- Full flags are evaluated only on the first beat; mid-packet full changes are ignored.
- drop_cnt saturates at all-ones and does not wrap.
- Reset, including mid-packet: state IDLE, all strobes 0, data/meta/port-map outputs 0, drop_cnt 0. The next accepted beat is treated as a first beat.
- Strobes are single-cycle pulses, never held.

Optional Feature:
ENQUEUE_AGENT_STATS_EN
- Defined: adds outputs enq_pkt_cnt[DROP_CNT_WIDTH], drop_buf_cnt and drop_pifo_cnt, all saturating and reset to 0.
  - A drop with both flags set increments both reason counters.
  - drop_cnt is unchanged.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package enqueue_agent_pkg: state enum (IDLE=0, ENQUEUE=1, DROP=2), DST field width 8, pifo_info field offsets (valid, last, rank, queue_id, field).
- One sub-module, sat_counter (parametrised width, inc, rst), reused for every counter.

Test Plan:
- 3-beat packet, dst=0x04, no full flags -> cycle 1: all 5 strobes and port map 00010; cycles 2-3: pkt_wr_en only; back to IDLE.
- 2-beat packet, dst=0x01, buffer_almost_full=00001 -> no strobes; drop_cnt 0->1; the following clean packet enqueues.
- Single-beat packet (last on first beat), pifo block 2 valid, pifo_almost_full=00100 -> dropped, state stays IDLE, drop_cnt+1.
- s_axis_wr_ready low for 3 cycles mid-packet -> s_axis_ready low, no strobes, state held; resumes cleanly.
- rst asserted in ENQUEUE after beat 2 of 4 -> outputs 0 next cycle; next beat is treated as a new first beat.
- DROP_CNT_WIDTH=2, 5 dropped packets -> drop_cnt stops at 3.

Source files
------------

// File: rtl/enqueue_agent_mc_pkg.sv
// Shared types and field positions for the multi-port enqueue agent.
// Optional statistics counters are enabled with ENQUEUE_AGENT_STATS_EN.
package enqueue_agent_pkg;

    // Packet-level state: waiting for a first beat, forwarding an accepted
    // packet, or swallowing the remainder of a rejected packet.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENQUEUE = 2'd1,
        ST_DROP    = 2'd2
    } state_e;

    // Width of the destination port field inside the SUME metadata.
    localparam int DST_FIELD_W = 8;

    // Layout of one pifo_info block (37 bits by default).
    localparam int PIFO_FIELD_LSB = 0;
    localparam int PIFO_FIELD_W   = 16;
    localparam int PIFO_QID_LSB   = 16;
    localparam int PIFO_QID_W     = 4;
    localparam int PIFO_RANK_LSB  = 20;
    localparam int PIFO_RANK_W    = 15;
    localparam int PIFO_LAST_BIT  = 35;
    localparam int PIFO_VALID_BIT = 36;

    // Odd bits of the destination field all address the CPU port.
    function automatic logic cpu_port_hit(input logic [DST_FIELD_W-1:0] dst);
        logic hit;
        hit = 1'b0;
        for (int j = 1; j < DST_FIELD_W; j += 2) begin
            hit = hit | dst[j];
        end
        return hit;
    endfunction

endpackage

// File: rtl/enqueue_agent_mc_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on rst.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: advance unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/enqueue_agent_mc.sv
// Enqueue agent: classifies each packet on its first beat and either forwards
// it to the packet/meta buffers and the PIFO, or drops the whole packet.
// All outputs are registered one cycle after the beat is accepted.
// Define ENQUEUE_AGENT_STATS_EN to add enqueue and per-reason drop counters.
//
// Handshake: a beat is accepted on a rising edge where s_axis_valid and
// s_axis_ready are both high; s_axis_ready follows s_axis_wr_ready and is
// forced low during reset. Data, keep and last must be stable while valid
// is high and ready is low.
module enqueue_agent_mc
    import enqueue_agent_pkg::*;
#(
    parameter int DATA_WIDTH        = 256,
    parameter int KEEP_WIDTH        = 32,
    parameter int SUME_WIDTH        = 128,
    parameter int PIFO_INFO_WIDTH   = 37,
    parameter int PIFO_BLOCK_COUNT  = 5,
    parameter int OUTPUT_PORT_COUNT = 5,
    parameter int DST_POS           = 24,
    parameter int DROP_CNT_WIDTH    = 32,
    localparam int PIFO_WIDTH       = PIFO_INFO_WIDTH * PIFO_BLOCK_COUNT,
    localparam int PKT_INFO_WIDTH   = DATA_WIDTH + KEEP_WIDTH + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                s_axis_pkt_data,
    input  logic [KEEP_WIDTH-1:0]                s_axis_pkt_keep,
    input  logic                                 s_axis_pkt_last,
    input  logic [SUME_WIDTH+PIFO_WIDTH-1:0]     s_axis_sume_meta,
    input  logic                                 s_axis_valid,
    output logic                                 s_axis_ready,
    input  logic                                 s_axis_wr_ready,
    input  logic [OUTPUT_PORT_COUNT-1:0]         s_axis_buffer_almost_full_bit_array,
    input  logic [PIFO_BLOCK_COUNT-1:0]          s_axis_pifo_almost_full_bit_array,
    output logic [PKT_INFO_WIDTH-1:0]            m_axis_pkt_info,
    output logic [SUME_WIDTH-1:0]                m_axis_sume_meta,
    output logic [PIFO_WIDTH-1:0]                m_axis_pifo_info,
    output logic [OUTPUT_PORT_COUNT-1:0]         m_axis_output_port_bit_array,
    output logic                                 m_axis_ctl_pkt_wr_en,
    output logic                                 m_axis_ctl_meta_wr_en,
    output logic                                 m_axis_ctl_pifo_enq,
    output logic                                 m_axis_ctl_pkt_addr_update,
    output logic                                 m_axis_ctl_meta_addr_update,
    output logic [1:0]                           dbg_state,
`ifdef ENQUEUE_AGENT_STATS_EN
    output logic [DROP_CNT_WIDTH-1:0]            enq_pkt_cnt,
    output logic [DROP_CNT_WIDTH-1:0]            drop_buf_cnt,
    output logic [DROP_CNT_WIDTH-1:0]            drop_pifo_cnt,
`endif
    output logic [DROP_CNT_WIDTH-1:0]            drop_cnt
);

    logic                         accepted;
    logic [SUME_WIDTH-1:0]        sume_in;
    logic [PIFO_WIDTH-1:0]        pifo_in;
    logic [OUTPUT_PORT_COUNT-1:0] port_map;
    logic                         buf_full;
    logic                         pifo_full;
    logic                         enq_event;
    logic                         drop_event;

    state_e                       state_q, state_d;
    logic [PKT_INFO_WIDTH-1:0]    pkt_info_q, pkt_info_d;
    logic [SUME_WIDTH-1:0]        sume_q, sume_d;
    logic [PIFO_WIDTH-1:0]        pifo_q, pifo_d;
    logic [OUTPUT_PORT_COUNT-1:0] port_map_q, port_map_d;
    logic                         pkt_wr_en_q, pkt_wr_en_d;
    logic                         meta_wr_en_q, meta_wr_en_d;
    logic                         pifo_enq_q, pifo_enq_d;
    logic                         pkt_addr_upd_q, pkt_addr_upd_d;
    logic                         meta_addr_upd_q, meta_addr_upd_d;

    assign s_axis_ready = s_axis_wr_ready & ~rst;
    assign accepted     = s_axis_valid & s_axis_ready;
    assign sume_in      = s_axis_sume_meta[SUME_WIDTH-1:0];
    assign pifo_in      = s_axis_sume_meta[SUME_WIDTH +: PIFO_WIDTH];

    // Destination map: even dst bits select regular ports, any odd bit the CPU port.
    always_comb begin
        port_map = '0;
        for (int i = 0; i < OUTPUT_PORT_COUNT - 1; i++) begin
            port_map[i] = sume_in[DST_POS + 2*i];
        end
        port_map[OUTPUT_PORT_COUNT-1] = cpu_port_hit(sume_in[DST_POS +: DST_FIELD_W]);
    end

    // Full checks: a busy buffer on any targeted port, or a busy PIFO block
    // that this packet carries valid info for.
    always_comb begin
        buf_full  = |(s_axis_buffer_almost_full_bit_array & port_map);
        pifo_full = 1'b0;
        for (int k = 0; k < PIFO_BLOCK_COUNT; k++) begin
            pifo_full = pifo_full |
                (s_axis_pifo_almost_full_bit_array[k] &
                 pifo_in[k*PIFO_INFO_WIDTH + PIFO_INFO_WIDTH - 1]);
        end
    end

    // Next-state and next-output decode for one accepted beat.
    always_comb begin
        state_d         = state_q;
        pkt_info_d      = pkt_info_q;
        sume_d          = sume_q;
        pifo_d          = pifo_q;
        port_map_d      = port_map_q;
        pkt_wr_en_d     = 1'b0;
        meta_wr_en_d    = 1'b0;
        pifo_enq_d      = 1'b0;
        pkt_addr_upd_d  = 1'b0;
        meta_addr_upd_d = 1'b0;
        enq_event       = 1'b0;
        drop_event      = 1'b0;
        if (accepted) begin
            pkt_info_d = {s_axis_pkt_data, s_axis_pkt_keep, s_axis_pkt_last};
            case (state_q)
                ST_IDLE: begin
                    if (!buf_full && !pifo_full) begin
                        pkt_wr_en_d     = 1'b1;
                        meta_wr_en_d    = 1'b1;
                        pifo_enq_d      = 1'b1;
                        pkt_addr_upd_d  = 1'b1;
                        meta_addr_upd_d = 1'b1;
                        sume_d          = sume_in;
                        pifo_d          = pifo_in;
                        port_map_d      = port_map;
                        enq_event       = 1'b1;
                        state_d         = s_axis_pkt_last ? ST_IDLE : ST_ENQUEUE;
                    end else begin
                        drop_event = 1'b1;
                        state_d    = s_axis_pkt_last ? ST_IDLE : ST_DROP;
                    end
                end
                ST_ENQUEUE: begin
                    pkt_wr_en_d    = 1'b1;
                    pkt_addr_upd_d = 1'b1;
                    if (s_axis_pkt_last) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (s_axis_pkt_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Packet FSM together with its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            pkt_info_q      <= '0;
            sume_q          <= '0;
            pifo_q          <= '0;
            port_map_q      <= '0;
            pkt_wr_en_q     <= 1'b0;
            meta_wr_en_q    <= 1'b0;
            pifo_enq_q      <= 1'b0;
            pkt_addr_upd_q  <= 1'b0;
            meta_addr_upd_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pkt_info_q      <= pkt_info_d;
            sume_q          <= sume_d;
            pifo_q          <= pifo_d;
            port_map_q      <= port_map_d;
            pkt_wr_en_q     <= pkt_wr_en_d;
            meta_wr_en_q    <= meta_wr_en_d;
            pifo_enq_q      <= pifo_enq_d;
            pkt_addr_upd_q  <= pkt_addr_upd_d;
            meta_addr_upd_q <= meta_addr_upd_d;
        end
    end

    assign m_axis_pkt_info              = pkt_info_q;
    assign m_axis_sume_meta             = sume_q;
    assign m_axis_pifo_info             = pifo_q;
    assign m_axis_output_port_bit_array = port_map_q;
    assign m_axis_ctl_pkt_wr_en         = pkt_wr_en_q;
    assign m_axis_ctl_meta_wr_en        = meta_wr_en_q;
    assign m_axis_ctl_pifo_enq          = pifo_enq_q;
    assign m_axis_ctl_pkt_addr_update   = pkt_addr_upd_q;
    assign m_axis_ctl_meta_addr_update  = meta_addr_upd_q;
    assign dbg_state                    = state_q;

    sat_counter #(.WIDTH(DROP_CNT_WIDTH)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_event),
        .cnt (drop_cnt)
    );

`ifdef ENQUEUE_AGENT_STATS_EN
    sat_counter #(.WIDTH(DROP_CNT_WIDTH)) u_enq_cnt (
        .clk (clk),
        .rst (rst),
        .inc (enq_event),
        .cnt (enq_pkt_cnt)
    );

    sat_counter #(.WIDTH(DROP_CNT_WIDTH)) u_drop_buf_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_event & buf_full),
        .cnt (drop_buf_cnt)
    );

    sat_counter #(.WIDTH(DROP_CNT_WIDTH)) u_drop_pifo_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_event & pifo_full),
        .cnt (drop_pifo_cnt)
    );
`else
    // Enqueue events only feed the optional statistics.
    logic unused_enq_event;
    assign unused_enq_event = enq_event;
`endif

endmodule
